// File: rtl/bcd_display_pkg.sv
// -----------------------------------------------------------------------------
// bcd_display_pkg
// Shared types and constants for the BCD 7-segment scan display.
//   state_t   : scan FSM states (IDLE, LOAD, DRIVE, GUARD)
//   SEG_*     : 7-bit active-high segment patterns, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
package bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        GUARD = 2'd3
    } state_t;

    //                                    gfedcba
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_7seg.sv
// -----------------------------------------------------------------------------
// bcd_to_7seg
// Combinational BCD nibble to 7-segment decoder (active-high segments).
// Values 10..15 are not BCD: they decode to a dash and raise o_invalid.
// Ports:
//   i_nibble   in  4  BCD digit
//   o_seg      out 7  segments, bit0 = a ... bit6 = g, 1 = lit
//   o_invalid  out 1  nibble > 9
// -----------------------------------------------------------------------------
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg,
    output logic       o_invalid
);

    always_comb begin
        o_seg     = SEG_DASH;
        o_invalid = 1'b0;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: begin
                o_seg     = SEG_DASH;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
// Time-multiplexed common-anode 7-segment driver for a packed BCD time bus.
// Each frame: one LOAD cycle snapshots the bus into a shadow register, then
// every digit is driven for SCAN_DIV cycles followed by GUARD_CYCLES blank
// cycles (ghosting guard). Frame period = 1 + N_DIGITS*(SCAN_DIV+GUARD_CYCLES).
// All outputs are registered and lag the FSM state/index by one cycle.
//
// Optional feature macro: BCD_DISPLAY_LZB_EN (leading-zero blanking).
//
// Ports:
//   i_clk          in  1           clock
//   i_rst          in  1           synchronous active-high reset
//   i_bcd_time     in  4*N_DIGITS  packed BCD, nibble k = digit k
//   i_enable       in  1           1 = scan, 0 = blank and return to IDLE
//   o_seg          out 7           segments a..g (polarity per ACTIVE_LOW)
//   o_dp           out 1           decimal point (polarity per ACTIVE_LOW)
//   o_an           out N_DIGITS    anode enables (polarity per ACTIVE_LOW)
//   o_frame_start  out 1           one-cycle pulse per snapshot
//   o_err          out 1           current frame holds a nibble > 9
//
// Handshake: none; i_bcd_time is sampled only in LOAD, i_enable is a level.
// -----------------------------------------------------------------------------
module bcd_display_scan
    import bcd_display_pkg::*;
#(
    parameter int                  N_DIGITS     = 6,
    parameter int                  SCAN_DIV     = 1000,
    parameter int                  GUARD_CYCLES = 4,
    parameter logic [N_DIGITS-1:0] DP_MASK      = N_DIGITS'(6'b010100),
    parameter bit                  ACTIVE_LOW   = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*N_DIGITS-1:0]   i_bcd_time,
    input  logic                    i_enable,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic [N_DIGITS-1:0]     o_an,
    output logic                    o_frame_start,
    output logic                    o_err
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
    // XOR masks applied at the output registers only
    localparam logic [N_DIGITS-1:0] AN_POL     = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]          SEG_POL    = {7{ACTIVE_LOW}};

    // FSM and datapath state
    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic [4*N_DIGITS-1:0]  r_shadow;

    // Output registers (physical polarity)
    logic [N_DIGITS-1:0]    r_an;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic                   r_frame_start;
    logic                   r_err;

    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_load;
    logic [4*N_DIGITS-1:0]  w_shadow_nxt;
    logic [6:0]             w_dec_seg [N_DIGITS];
    logic [N_DIGITS-1:0]    w_dec_inv;
    logic                   w_frame_err;
    logic [N_DIGITS-1:0]    w_blank;
    logic [N_DIGITS-1:0]    w_an_act;
    logic [6:0]             w_seg_act;
    logic                   w_dp_act;

    assign w_load       = i_enable && (r_state == LOAD);
    assign w_shadow_nxt = w_load ? i_bcd_time : r_shadow;

    // The decoders look at the next shadow value. In LOAD this is the live
    // bus, so their invalid flags give the error status of the frame being
    // captured; outside LOAD it equals the shadow, so their segments are the
    // ones to display while driving.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
        bcd_to_7seg u_dec (
            .i_nibble  (w_shadow_nxt[4*k +: 4]),
            .o_seg     (w_dec_seg[k]),
            .o_invalid (w_dec_inv[k])
        );
    end

    assign w_frame_err = |w_dec_inv;

`ifdef BCD_DISPLAY_LZB_EN
    // Leading-zero blanking: digits from the top downward that are zero
    // (contiguously) are blanked for the whole frame. Digit 0 always shows.
    logic [N_DIGITS-1:0] r_blank;
    logic [N_DIGITS-1:0] w_lzb_mask;
    logic                w_zero_run;

    always_comb begin
        w_lzb_mask = '0;
        w_zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            w_zero_run    = w_zero_run && (i_bcd_time[4*k +: 4] == 4'd0);
            w_lzb_mask[k] = w_zero_run;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blank <= '0;
        end else if (w_load) begin
            r_blank <= w_lzb_mask;
        end
    end

    assign w_blank = r_blank;
`else
    assign w_blank = '0;
`endif

    // Next-state logic. The counter restarts at 0 on every state change and
    // on every digit change when there is no guard gap.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = '0;
        if (!i_enable) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = LOAD;
                end
                LOAD: begin
                    w_state_nxt = DRIVE;
                    w_idx_nxt   = '0;
                end
                DRIVE: begin
                    if (r_cnt == DRIVE_LAST) begin
                        if (GUARD_CYCLES > 0) begin
                            w_state_nxt = GUARD;
                        end else if (r_idx == IDX_LAST) begin
                            w_state_nxt = LOAD;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (r_cnt == GUARD_LAST) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = LOAD;
                        end else begin
                            w_state_nxt = DRIVE;
                            w_idx_nxt   = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Active-high view of the display for the next cycle. Dropping i_enable
    // blanks the outputs on the same edge the FSM returns to IDLE.
    always_comb begin
        w_an_act  = '0;
        w_seg_act = SEG_BLANK;
        w_dp_act  = 1'b0;
        if (i_enable && (r_state == DRIVE)) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if ((r_idx == IDX_W'(k)) && !w_blank[k]) begin
                    w_an_act[k] = 1'b1;
                    w_seg_act   = w_dec_seg[k];
                    w_dp_act    = DP_MASK[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_shadow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_an          <= AN_POL;
            r_seg         <= SEG_POL;
            r_dp          <= ACTIVE_LOW;
            r_frame_start <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_an          <= w_an_act ^ AN_POL;
            r_seg         <= w_seg_act ^ SEG_POL;
            r_dp          <= w_dp_act ^ ACTIVE_LOW;
            r_frame_start <= w_load;
            if (w_load) begin
                r_err <= w_frame_err;
            end
        end
    end

    assign o_an          = r_an;
    assign o_seg         = r_seg;
    assign o_dp          = r_dp;
    assign o_frame_start = r_frame_start;
    assign o_err         = r_err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scan
// Self-checking bench for bcd_display_scan (SCAN_DIV=4, GUARD_CYCLES=1,
// N_DIGITS=6, ACTIVE_LOW=0). A frame-position reference model predicts every
// output on every cycle; directed steps cover the test plan, then a random
// phase mixes bus changes, enable drops and resets.
// Honours BCD_DISPLAY_LZB_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_bcd_display_scan;

    localparam int ND    = 6;
    localparam int SD    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = SD + GC;
    localparam int FRAME = 1 + ND * SLOT;

    // ---------------- clock / reset ----------------
    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [23:0]   i_bcd_time;
    logic          i_enable;
    logic [6:0]    o_seg;
    logic          o_dp;
    logic [ND-1:0] o_an;
    logic          o_frame_start;
    logic          o_err;

    always #5 i_clk = ~i_clk;

    bcd_display_scan #(
        .N_DIGITS     (ND),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (GC),
        .DP_MASK      (6'b010100),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_bcd_time    (i_bcd_time),
        .i_enable      (i_enable),
        .o_seg         (o_seg),
        .o_dp          (o_dp),
        .o_an          (o_an),
        .o_frame_start (o_frame_start),
        .o_err         (o_err)
    );

    // ---------------- scoreboard state ----------------
    int           n_assert = 0;
    int           n_fail   = 0;
    logic [15:0]  exp_q[$];   // {frame_start, err, dp, seg[6:0], an[5:0]}

    // Reference model: m_ph = -1 when idle, else position in the frame that
    // the DUT state occupies after the next edge (0 = snapshot cycle).
    int           m_ph     = -1;
    logic [23:0]  m_shadow = '0;
    logic         m_err    = 1'b0;
    logic [5:0]   m_blank  = '0;
    logic [5:0]   m_dp_mask = 6'b010100;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

`ifdef BCD_DISPLAY_LZB_EN
    // Blank every digit above the most significant non-zero digit.
    function automatic logic [5:0] ref_blank(input logic [23:0] v);
        logic [5:0] m;
        int         h;
        m = '0;
        h = 0;
        for (int k = 0; k < ND; k++) if (v[4*k +: 4] != 4'd0) h = k;
        for (int k = 1; k < ND; k++) if (k > h) m[k] = 1'b1;
        return m;
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver: one clock step with prediction + check ----------------
    task automatic tick();
        logic [5:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        fs;
        logic [15:0] e;
        int          j;
        int          d;
        an = '0; seg = '0; dp = 1'b0; fs = 1'b0;
        if (i_rst) begin
            m_ph = -1; m_shadow = '0; m_err = 1'b0; m_blank = '0;
        end else if (!i_enable) begin
            m_ph = -1;
        end else if (m_ph < 0) begin
            m_ph = 0;
        end else if (m_ph == 0) begin
            fs       = 1'b1;
            m_shadow = i_bcd_time;
            m_err    = 1'b0;
            for (int k = 0; k < ND; k++) if (i_bcd_time[4*k +: 4] > 4'd9) m_err = 1'b1;
`ifdef BCD_DISPLAY_LZB_EN
            m_blank  = ref_blank(i_bcd_time);
`endif
            m_ph = 1;
        end else begin
            j = m_ph - 1;
            d = j / SLOT;
            if ((j % SLOT) < SD && !m_blank[d]) begin
                an  = 6'(1 << d);
                seg = ref_seg(m_shadow[4*d +: 4]);
                dp  = m_dp_mask[d];
            end
            m_ph = (m_ph == FRAME - 1) ? 0 : m_ph + 1;
        end
        exp_q.push_back({fs, m_err, dp, seg, an});
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        chk("an",          32'(o_an),          32'(e[5:0]));
        chk("seg",         32'(o_seg),         32'(e[12:6]));
        chk("dp",          32'(o_dp),          32'(e[13]));
        chk("err",         32'(o_err),         32'(e[14]));
        chk("frame_start", 32'(o_frame_start), 32'(e[15]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the model says the DUT sits in the wanted frame slot.
    // want_guard=0: a DRIVE cycle of digit dig (dig<0 = any digit).
    task automatic run_until(input int dig, input bit want_guard);
        int  j;
        bit  hit;
        hit = 1'b0;
        for (int i = 0; i < 3 * FRAME && !hit; i++) begin
            if (m_ph >= 1) begin
                j = m_ph - 1;
                if (want_guard ? ((j % SLOT) == SD)
                               : ((j % SLOT) < SD && (dig < 0 || (j / SLOT) == dig)))
                    hit = 1'b1;
            end
            if (!hit) tick();
        end
        n_assert++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL run_until observed=timeout expected=slot_reached");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        i_rst = 1'b1; i_enable = 1'b0; i_bcd_time = '0;
        run(2);                                   // reset state checked

        // basic frame: walking anodes, digits 6..1, period 31
        i_rst = 1'b0; i_enable = 1'b1; i_bcd_time = 24'h123456;
        run(2 * FRAME + 3);

        // tear-free: change bus while digit 2 is driven
        run_until(2, 1'b0);
        i_bcd_time = 24'h000000;
        run(2 * FRAME);

        // invalid nibble -> dash and err for a full frame, then clears
        i_bcd_time = 24'h00A009;
        run(FRAME + 2);
        i_bcd_time = 24'h000009;
        run(2 * FRAME);

        // drop enable for one cycle during DRIVE, then re-enable
        i_bcd_time = 24'h987650;
        run_until(3, 1'b0);
        i_enable = 1'b0;
        tick();
        i_enable = 1'b1;
        run(FRAME + 4);

        // reset during GUARD
        run_until(-1, 1'b1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        run(2 * FRAME + 2);

        // leading zeros (blanked only when BCD_DISPLAY_LZB_EN is defined)
        i_bcd_time = 24'h000070;
        run(2 * FRAME + 2);
        i_bcd_time = 24'h000000;
        run(2 * FRAME + 2);
        i_bcd_time = 24'h100000;
        run(2 * FRAME + 2);

        // random phase
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                for (int k = 0; k < ND; k++) begin
                    if ($urandom_range(0, 2) == 0) i_bcd_time[4*k +: 4] = 4'd0;
                    else                           i_bcd_time[4*k +: 4] = 4'($urandom_range(0, 11));
                end
            end
            i_enable = ($urandom_range(0, 39) != 0);
            i_rst    = ($urandom_range(0, 149) == 0);
            tick();
        end
        i_rst = 1'b0; i_enable = 1'b1;
        run(FRAME + 2);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
